// File: rtl/axilite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axilite_pkg
// Description : Shared FSM state type and AXI response codes for the
//               AXI-Lite request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axilite_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotating-priority pick; the search starts one
//               past the previous winner and wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_onehot_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    logic [IDX_W:0] cand;
    logic           found;

    always_comb begin
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        found          = 1'b0;
        cand           = '0;
        // One extra bit holds last_grant + i before the modulo wrap.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_grant_i} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req_i[cand[IDX_W-1:0]]) begin
                found                             = 1'b1;
                grant_idx_o                       = cand[IDX_W-1:0];
                grant_onehot_o[cand[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axilite_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axilite_req_arbiter
// Description : Round-robin sharing of one AXI-Lite command port among
//               NUM_REQ requesters, one transaction in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module axilite_req_arbiter
    import axilite_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT        = 1024
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic [NUM_REQ-1:0]                 s_req_valid,
    output logic [NUM_REQ-1:0]                 s_req_ready,
    input  logic [NUM_REQ-1:0]                 s_req_write,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]  s_req_addr,
    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]  s_req_wdata,
    input  logic [NUM_REQ*AXI_DATA_WIDTH/8-1:0] s_req_wstrb,
    output logic [NUM_REQ-1:0]                 s_rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]          s_rsp_rdata,
    output logic [1:0]                         s_rsp_resp,
    output logic                               m_cmd_valid,
    input  logic                               m_cmd_ready,
    output logic                               m_cmd_write,
    output logic [AXI_ADDR_WIDTH-1:0]          m_cmd_addr,
    output logic [AXI_DATA_WIDTH-1:0]          m_cmd_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]        m_cmd_wstrb,
    input  logic                               m_rsp_valid,
    output logic                               m_rsp_ready,
    input  logic [AXI_DATA_WIDTH-1:0]          m_rsp_rdata,
    input  logic [1:0]                         m_rsp_resp
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t                state_q, state_d;
    logic [IDX_W-1:0]          grant_q, grant_d;
    logic [IDX_W-1:0]          last_grant_q, last_grant_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      cmd_write_q, cmd_write_d;
    logic [AXI_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [AXI_DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [STRB_W-1:0]         cmd_wstrb_q, cmd_wstrb_d;
    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                rsp_resp_q, rsp_resp_d;

    logic [NUM_REQ-1:0]        w_arb_onehot;
    logic [IDX_W-1:0]          w_arb_idx;
    logic                      w_expired;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i          (s_req_valid),
        .last_grant_i   (last_grant_q),
        .grant_onehot_o (w_arb_onehot),
        .grant_idx_o    (w_arb_idx)
    );

    // A zero TIMEOUT disables expiry entirely.
    assign w_expired = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    assign s_req_ready = (state_q == IDLE) ? w_arb_onehot : '0;
    assign m_cmd_valid = (state_q == ISSUE);
    assign m_rsp_ready = (state_q == WAIT_RSP);
    assign m_cmd_write = cmd_write_q;
    assign m_cmd_addr  = cmd_addr_q;
    assign m_cmd_wdata = cmd_wdata_q;
    assign m_cmd_wstrb = cmd_wstrb_q;
    assign s_rsp_valid = rsp_valid_q;
    assign s_rsp_rdata = rsp_rdata_q;
    assign s_rsp_resp  = rsp_resp_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_wstrb_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_resp_q   <= RESP_OKAY;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_wstrb_q  <= cmd_wstrb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_resp_q   <= rsp_resp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cmd_wstrb_d  = cmd_wstrb_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_resp_d   = rsp_resp_q;

        case (state_q)
            IDLE: begin
                if (|(s_req_valid & w_arb_onehot)) begin
                    grant_d     = w_arb_idx;
                    cmd_write_d = s_req_write[w_arb_idx];
                    cmd_addr_d  = s_req_addr[int'(w_arb_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                    cmd_wdata_d = s_req_wdata[int'(w_arb_idx)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                    cmd_wstrb_d = s_req_wstrb[int'(w_arb_idx)*STRB_W +: STRB_W];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (m_cmd_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A real response takes priority over a coincident expiry.
                if (m_rsp_valid) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_rdata_d          = m_rsp_rdata;
                    rsp_resp_d           = m_rsp_resp;
                    last_grant_d         = grant_q;
                    state_d              = IDLE;
                end else if (w_expired) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_rdata_d          = '0;
                    rsp_resp_d           = RESP_DECERR;
                    last_grant_d         = grant_q;
                    state_d              = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axilite_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axilite_req_arbiter
// Description : Scoreboard bench with requester and master models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axilite_req_arbiter;
    import axilite_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    logic [N-1:0]    s_req_valid, s_req_ready, s_req_write;
    logic [N*AW-1:0] s_req_addr;
    logic [N*DW-1:0] s_req_wdata;
    logic [N*SW-1:0] s_req_wstrb;
    logic [N-1:0]    s_rsp_valid;
    logic [DW-1:0]   s_rsp_rdata;
    logic [1:0]      s_rsp_resp;
    logic            m_cmd_valid, m_cmd_ready, m_cmd_write;
    logic [AW-1:0]   m_cmd_addr;
    logic [DW-1:0]   m_cmd_wdata;
    logic [SW-1:0]   m_cmd_wstrb;
    logic            m_rsp_valid, m_rsp_ready;
    logic [DW-1:0]   m_rsp_rdata;
    logic [1:0]      m_rsp_resp;

    always #5 ACLK = ~ACLK;

    axilite_req_arbiter #(
        .NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_write(s_req_write),
        .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb),
        .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata), .s_rsp_resp(s_rsp_resp),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_write(m_cmd_write),
        .m_cmd_addr(m_cmd_addr), .m_cmd_wdata(m_cmd_wdata), .m_cmd_wstrb(m_cmd_wstrb),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
        .m_rsp_rdata(m_rsp_rdata), .m_rsp_resp(m_rsp_resp)
    );

    typedef struct {
        int          id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    typedef struct {
        logic [N-1:0] onehot;
        logic [31:0]  rdata;
        logic [1:0]   resp;
        int           waits;
    } rsp_t;

    int   exp_grant_q[$];
    cmd_t exp_cmd_q[$];
    rsp_t exp_rsp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Requester configuration (written by stimulus) and progress (written by model).
    logic        rq_wr    [N] = '{default: 1'b0};
    logic [31:0] rq_addr  [N] = '{default: 32'h0};
    logic [31:0] rq_wdata [N] = '{default: 32'h0};
    logic [3:0]  rq_wstrb [N] = '{default: 4'h0};
    int          req_total[N] = '{default: 0};
    int          req_done [N] = '{default: 0};
    int          pulse_tag[N] = '{default: 0};
    int          pulse_seen[N] = '{default: 0};

    int          mst_hold    = 0;
    bit          mst_respond = 1'b1;
    logic [1:0]  mst_resp    = RESP_OKAY;

    int          mst_st   = 0;
    int          hold_cnt = 0;
    int          wait_cnt = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    logic [31:0] cur_rdata = 32'h0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0], 16'hC0DE};
    endfunction

    // Drive phase: right after the falling edge, set inputs for the next rising edge.
    task automatic drive_inputs();
        cmd_t c;
        for (int i = 0; i < N; i++) begin
            s_req_valid[i]            = (req_done[i] < req_total[i]) || (pulse_seen[i] != pulse_tag[i]);
            pulse_seen[i]             = pulse_tag[i];
            s_req_write[i]            = rq_wr[i];
            s_req_addr[i*AW +: AW]    = rq_addr[i];
            s_req_wdata[i*DW +: DW]   = rq_wdata[i];
            s_req_wstrb[i*SW +: SW]   = rq_wstrb[i];
        end
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_rdata = '0;
        m_rsp_resp  = RESP_OKAY;
        if (mst_st == 0 && m_cmd_valid) begin
            if (exp_cmd_q.size() == 0) begin
                chk("cmd_unexpected", m_cmd_valid, 1'b0);
            end else if (hold_cnt < mst_hold) begin
                hold_cnt++;
                c = exp_cmd_q[0];
                chk("cmd_stable_write", m_cmd_write, c.wr);
                chk("cmd_stable_addr", m_cmd_addr, c.addr);
                chk("cmd_stable_wdata", m_cmd_wdata, c.wdata);
                chk("cmd_stable_wstrb", m_cmd_wstrb, c.wstrb);
            end else begin
                m_cmd_ready = 1'b1;
            end
        end
        if (mst_st == 1 && mst_respond && m_rsp_ready) begin
            m_rsp_valid = 1'b1;
            m_rsp_rdata = cur_rdata;
            m_rsp_resp  = mst_resp;
        end
    endtask

    // Observe phase: just before the rising edge, record what that edge will do.
    task automatic observe();
        cmd_t c;
        rsp_t r;
        int   g;
        cyc++;
        if (ARESET) begin
            mst_st   = 0;
            hold_cnt = 0;
            wait_cnt = 0;
            exp_rsp_q.delete();
            exp_cmd_q.delete();
            for (int i = 0; i < N; i++) req_done[i] = req_total[i];
            return;
        end
        if (s_rsp_valid != '0) begin
            if (exp_rsp_q.size() == 0) begin
                chk("rsp_unexpected", s_rsp_valid, '0);
            end else begin
                r = exp_rsp_q.pop_front();
                chk("rsp_valid", s_rsp_valid, r.onehot);
                chk("rsp_rdata", s_rsp_rdata, r.rdata);
                chk("rsp_resp", s_rsp_resp, r.resp);
                chk("rsp_wait_cycles", wait_cnt, r.waits);
            end
        end
        chk("ready_onehot0", $onehot0(s_req_ready), 1'b1);
        for (int i = 0; i < N; i++) begin
            if (s_req_valid[i] && s_req_ready[i]) begin
                acc_cyc = cyc;
                if (exp_grant_q.size() == 0) begin
                    chk("grant_unexpected", i, N);
                end else begin
                    g = exp_grant_q.pop_front();
                    chk("grant_idx", i, g);
                    exp_cmd_q.push_back('{g, rq_wr[g], rq_addr[g], rq_wdata[g], rq_wstrb[g]});
                end
                if (req_done[i] < req_total[i]) req_done[i]++;
            end
        end
        if (mst_st == 0) begin
            if (m_cmd_valid && m_cmd_ready && exp_cmd_q.size() > 0) begin
                c = exp_cmd_q.pop_front();
                chk("cmd_write", m_cmd_write, c.wr);
                chk("cmd_addr", m_cmd_addr, c.addr);
                chk("cmd_wdata", m_cmd_wdata, c.wdata);
                chk("cmd_wstrb", m_cmd_wstrb, c.wstrb);
                if (mst_hold == 0) chk("cmd_latency", cyc - acc_cyc, 1);
                cur_rdata   = rdata_of(c.addr);
                r.onehot    = '0;
                r.onehot[c.id] = 1'b1;
                r.rdata     = mst_respond ? cur_rdata : 32'h0;
                r.resp      = mst_respond ? mst_resp : RESP_DECERR;
                r.waits     = mst_respond ? 1 : TO;
                exp_rsp_q.push_back(r);
                mst_st   = 1;
                hold_cnt = 0;
                wait_cnt = 0;
            end
        end else begin
            if (m_rsp_ready) begin
                wait_cnt++;
                if (m_rsp_valid) mst_st = 0;
            end else begin
                mst_st = 0;
            end
        end
    endtask

    initial begin : model
        s_req_valid = '0; s_req_write = '0; s_req_addr = '0;
        s_req_wdata = '0; s_req_wstrb = '0;
        m_cmd_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = '0; m_rsp_resp = '0;
        forever begin
            @(negedge ACLK);
            drive_inputs();
            #3;
            observe();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #2;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb, input int cnt);
        rq_wr[i]     = wr;
        rq_addr[i]   = addr;
        rq_wdata[i]  = wdata;
        rq_wstrb[i]  = wstrb;
        req_total[i] = req_total[i] + cnt;
    endtask

    function automatic bit quiet();
        bit q;
        q = (exp_grant_q.size() == 0) && (exp_cmd_q.size() == 0) && (exp_rsp_q.size() == 0)
            && (mst_st == 0) && !m_cmd_valid && !m_rsp_ready && (s_rsp_valid == '0);
        for (int i = 0; i < N; i++) if (req_done[i] < req_total[i]) q = 1'b0;
        return q;
    endfunction

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick(1);
            if (quiet()) begin
                ok = 1'b1;
                break;
            end
        end
        chk({"drain_", tag}, ok, 1'b1);
    endtask

    task automatic wait_for(input string tag, input bit want_wait);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (want_wait ? (mst_st == 1) : m_cmd_valid) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        chk({"reach_", tag}, ok, 1'b1);
    endtask

    initial begin : stimulus
        tick(3);
        chk("rst_s_req_ready", s_req_ready, '0);
        chk("rst_m_cmd_valid", m_cmd_valid, 1'b0);
        chk("rst_m_rsp_ready", m_rsp_ready, 1'b0);
        chk("rst_s_rsp_valid", s_rsp_valid, '0);
        chk("rst_m_cmd_addr", m_cmd_addr, '0);
        chk("rst_s_rsp_rdata", s_rsp_rdata, '0);
        chk("rst_s_rsp_resp", s_rsp_resp, '0);
        ARESET = 1'b0;
        tick(1);

        // Single read from requester 0.
        exp_grant_q.push_back(0);
        set_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1);
        drain("single_read");

        // Fresh reset, then all requesters contend continuously.
        ARESET = 1'b1;
        tick(2);
        ARESET = 1'b0;
        tick(1);
        foreach (exp_grant_q[k]) exp_grant_q.delete();
        exp_grant_q = '{0, 1, 2, 3, 0};
        set_req(0, 1'b0, 32'h100, 32'h0, 4'h0, 2);
        set_req(1, 1'b1, 32'h104, 32'hA1A1_0001, 4'h3, 1);
        set_req(2, 1'b0, 32'h108, 32'h0, 4'h0, 1);
        set_req(3, 1'b1, 32'h10C, 32'hB3B3_0003, 4'hC, 1);
        drain("rotation");

        // Write with a back-pressured command port and a SLVERR response.
        mst_hold = 5;
        mst_resp = RESP_SLVERR;
        exp_grant_q.push_back(2);
        set_req(2, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 1);
        drain("held_write");
        mst_hold = 0;
        mst_resp = RESP_OKAY;

        // Master never answers: timeout yields DECERR.
        mst_respond = 1'b0;
        exp_grant_q.push_back(3);
        set_req(3, 1'b0, 32'h80, 32'h0, 4'h0, 1);
        drain("timeout");
        mst_respond = 1'b1;

        // Requester 1 pulses valid while requester 0 owns the port.
        mst_hold = 4;
        exp_grant_q.push_back(0);
        set_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 1);
        wait_for("issue_pulse", 1'b0);
        pulse_tag[1] = pulse_tag[1] + 1;
        drain("dropped_request");
        mst_hold = 0;

        // Reset mid-transaction: no response, and requester 0 wins next.
        mst_respond = 1'b0;
        exp_grant_q.push_back(1);
        set_req(1, 1'b0, 32'h30, 32'h0, 4'h0, 1);
        wait_for("wait_rsp", 1'b1);
        ARESET = 1'b1;
        tick(1);
        ARESET = 1'b0;
        tick(4);
        chk("post_reset_m_rsp_ready", m_rsp_ready, 1'b0);
        mst_respond = 1'b1;
        exp_grant_q = '{0, 1};
        set_req(0, 1'b0, 32'h50, 32'h0, 4'h0, 1);
        set_req(1, 1'b1, 32'h54, 32'hCAFE_F00D, 4'h5, 1);
        drain("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
